ctrl_seq: RTL

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) plus control matrix that decodes the instruction-register opcode into the per-state control word. It sits directly upstream of the buffer-style registers (PC, MAR, IR, A, B, OUT) and drives their LOAD/ENABLE pins; it also stops the machine on HLT.

---
 rtl/ctrl_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter (T1..T6) plus the
// control matrix that decodes OPCODE into the per-state control word.
module ctrl_seq (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] OPCODE,
    output logic [5:0] T,
    output logic       CP,
    output logic       EP,
    output logic       LM,
    output logic       CE,
    output logic       LI,
    output logic       EI,
    output logic       LA,
    output logic       EA,
    output logic       SU,
    output logic       EU,
    output logic       LB,
    output logic       LO,
    output logic       HALT
);

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } state_e;

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    state_e state_q, state_d;
    logic   halt_q, halt_d;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StT1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            unique case (state_q)
                StT1:    state_d = StT2;
                StT2:    state_d = StT3;
                StT3:    state_d = StT4;
                StT4: begin
                    // HLT freezes the ring at T4 rather than advancing
                    if (OPCODE == OpHlt) begin
                        halt_d = 1'b1;
                    end else begin
                        state_d = StT5;
                    end
                end
                StT5:    state_d = StT6;
                StT6:    state_d = StT1;
                default: state_d = StT1;
            endcase
        end
    end

    always_comb begin
        CP = 1'b0;
        EP = 1'b0;
        LM = 1'b0;
        CE = 1'b0;
        LI = 1'b0;
        EI = 1'b0;
        LA = 1'b0;
        EA = 1'b0;
        SU = 1'b0;
        EU = 1'b0;
        LB = 1'b0;
        LO = 1'b0;
        // No bus drive while reset is held or the machine is halted
        if (!CLR && !halt_q) begin
            unique case (state_q)
                StT1: begin
                    EP = 1'b1;
                    LM = 1'b1;
                end
                StT2: CP = 1'b1;
                StT3: begin
                    CE = 1'b1;
                    LI = 1'b1;
                end
                StT4: begin
                    if (OPCODE == OpLda || OPCODE == OpAdd || OPCODE == OpSub) begin
                        EI = 1'b1;
                        LM = 1'b1;
                    end else if (OPCODE == OpOut) begin
                        EA = 1'b1;
                        LO = 1'b1;
                    end
                end
                StT5: begin
                    if (OPCODE == OpLda) begin
                        CE = 1'b1;
                        LA = 1'b1;
                    end else if (OPCODE == OpAdd || OPCODE == OpSub) begin
                        CE = 1'b1;
                        LB = 1'b1;
                    end
                end
                StT6: begin
                    if (OPCODE == OpAdd || OPCODE == OpSub) begin
                        LA = 1'b1;
                        EU = 1'b1;
                        SU = (OPCODE == OpSub);
                    end
                end
                default: ;
            endcase
        end
    end

    assign T    = state_q;
    assign HALT = halt_q;

endmodule
